// File: rtl/pack_pkg.sv
// Shared definitions for the video pack scheduler: pack field layout and the
// source-rotation helper used to pick the next enabled source.
package pack_pkg;

  localparam int unsigned PACK_W      = 50;
  localparam int unsigned PACK_VS_IDX = 49;
  localparam int unsigned PACK_HS_IDX = 48;
  localparam int unsigned PACK_DE_IDX = 47;

  // Upper bound on the number of sources the helper can scan.
  localparam int unsigned MAX_SRC   = 16;
  localparam int unsigned SEL_MAX_W = 4;

  // First enabled index after sel, scanning sel+1 .. sel+num-1 modulo num.
  // Returns sel unchanged when no other source is enabled.
  function automatic logic [SEL_MAX_W-1:0] next_enabled(
    input logic [SEL_MAX_W-1:0] sel,
    input logic [MAX_SRC-1:0]   mask,
    input int unsigned          num
  );
    logic [SEL_MAX_W-1:0] res;
    logic                 found;
    int unsigned          idx;
    res   = sel;
    found = 1'b0;
    for (int unsigned k = 1; k < MAX_SRC; k++) begin
      if (!found && (k < num)) begin
        idx = (32'(sel) + k) % num;
        if (mask[idx[SEL_MAX_W-1:0]]) begin
          res   = idx[SEL_MAX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stability counter.
// Ports:
//   clk, rstn  clock, async active-low reset
//   i_btn      raw asynchronous button, active-high
//   o_level    debounced stable level
//   o_press    one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
  parameter int unsigned DEB_TICKS = 5_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, then accept a new level only after it has held for DEB_TICKS cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_TICKS - 1)) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/pack_scheduler.sv
// Frame-synchronous selector of NUM_SRC video packs. Source changes (manual
// button or auto rotation) take effect only on the active vsync edge of the
// source currently shown; disabled sources are skipped, and a disabled current
// source is left immediately.
// Ports:
//   clk, rstn  clock, async active-low reset
//   switch     raw "next source" button
//   i_auto     enable auto rotation every AUTO_FRAMES frames
//   i_src_en   per-source enable mask
//   i_packs    source k at bits [k*PACK_W +: PACK_W]
//   o_pack     selected pack (registered, one cycle behind o_sel)
//   o_sel      current source index
//   o_pending  manual request waiting for a frame boundary
//   o_switch   one-cycle pulse aligned with an o_sel change
module pack_scheduler
  import pack_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DEB_TICKS   = 5_000_000,
  parameter int unsigned AUTO_FRAMES = 60,
  parameter int unsigned INIT_SEL    = 0,
  parameter logic        VS_POL      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      switch,
  input  logic                      i_auto,
  input  logic [NUM_SRC-1:0]        i_src_en,
  input  logic [NUM_SRC*PACK_W-1:0] i_packs,
  output logic [PACK_W-1:0]         o_pack,
  output logic [$clog2(NUM_SRC)-1:0] o_sel,
  output logic                      o_pending,
  output logic                      o_switch
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC);
  localparam int unsigned FC_W  = $clog2(AUTO_FRAMES + 1);

  logic [PACK_W-1:0] r_pack;
  logic [SEL_W-1:0]  r_sel;
  logic              r_pending;
  logic              r_switch;
  logic              r_vs_prev;
  logic [FC_W-1:0]   r_frame_cnt;

  logic              w_level;
  logic              w_press;
  logic              w_req;
  logic [PACK_W-1:0] w_cur_pack;
  logic              w_cur_vs;
  logic              w_next_vs;
  logic [SEL_W-1:0]  w_next;
  logic              w_bnd;
  logic              w_cur_dis;
  logic              w_mask_zero;
  logic              w_auto_due;
  logic              w_bnd_adv;
  logic              w_adv;
  logic              w_move;

  btn_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_btn (
    .clk     (clk),
    .rstn    (rstn),
    .i_btn   (switch),
    .o_level (w_level),
    .o_press (w_press)
  );

  // Press pulse qualified by the settled level it was generated from.
  assign w_req = w_press & w_level;

  assign w_next = SEL_W'(next_enabled(SEL_MAX_W'(r_sel), MAX_SRC'(i_src_en), NUM_SRC));

  // Current pack, and the vsync of the candidate source so the edge detector
  // can be reloaded on a switch without seeing a false edge.
  always_comb begin
    w_cur_pack = '0;
    w_next_vs  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_cur_pack = i_packs[k*PACK_W +: PACK_W];
      end
      if (w_next == SEL_W'(k)) begin
        w_next_vs = i_packs[k*PACK_W + PACK_VS_IDX];
      end
    end
  end

  assign w_cur_vs    = w_cur_pack[PACK_VS_IDX];
  assign w_bnd       = (w_cur_vs == VS_POL) && (r_vs_prev != VS_POL);
  assign w_cur_dis   = ~i_src_en[r_sel];
  assign w_mask_zero = (i_src_en == '0);
  assign w_auto_due  = i_auto && (r_frame_cnt == FC_W'(AUTO_FRAMES - 1));
  // A press landing on the boundary cycle is honoured at that boundary.
  assign w_bnd_adv   = w_bnd && (r_pending || w_req || w_auto_due);
  assign w_adv       = w_cur_dis || w_bnd_adv;
  assign w_move      = w_adv && (w_next != r_sel);

  // Selection, pending request, frame counter and output pack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pack      <= '0;
      r_sel       <= SEL_W'(INIT_SEL);
      r_pending   <= 1'b0;
      r_switch    <= 1'b0;
      r_vs_prev   <= VS_POL;
      r_frame_cnt <= '0;
    end else begin
      r_pack   <= w_mask_zero ? '0 : w_cur_pack;
      r_switch <= w_move;

      if (w_move) begin
        r_sel     <= w_next;
        r_vs_prev <= w_next_vs;
      end else begin
        r_vs_prev <= w_cur_vs;
      end

      if (w_bnd_adv || w_move) begin
        r_pending <= 1'b0;
      end else if (w_req) begin
        r_pending <= 1'b1;
      end

      if (!i_auto || w_adv) begin
        r_frame_cnt <= '0;
      end else if (w_bnd) begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
    end
  end

  assign o_pack    = r_pack;
  assign o_sel     = r_sel;
  assign o_pending = r_pending;
  assign o_switch  = r_switch;

endmodule
